// File: rtl/escalonador_jogo_if.sv
// Control bundle between the Pong input/score logic and the game-timing controller.
// All signals are single-cycle strobes or registered status; no handshake back-pressure.
interface escalonador_jogo_if #(
    parameter int NIVEIS = 8
);
    localparam int NW = (NIVEIS > 1) ? $clog2(NIVEIS) : 1;

    // Command pulses are high for exactly one clock and sampled at the rising
    // edge; tick/saque are one-cycle strobes, the rest is level status.
    logic          iniciar;
    logic          pausar;
    logic          rebatida;
    logic          ponto;
    logic          tick;
    logic          saque;
    logic          jogando;
    logic [NW-1:0] nivel;
    logic [1:0]    estado;

    modport master (
        output iniciar, pausar, rebatida, ponto,
        input  tick, saque, jogando, nivel, estado
    );

    modport slave (
        input  iniciar, pausar, rebatida, ponto,
        output tick, saque, jogando, nivel, estado
    );
endinterface

// File: rtl/escalonador_jogo.sv
// Game-timing controller: prescaler-driven ball tick with serve delay,
// per-hit speed levels and pause/resume.
module escalonador_jogo #(
    parameter int PERIODO_BASE = 50000,
    parameter int PASSO        = 5000,
    parameter int NIVEIS       = 8,
    parameter int TICKS_SAQUE  = 60
) (
    input logic               clock,
    input logic               zera_n,
    escalonador_jogo_if.slave bus
);
    localparam int CW = (PERIODO_BASE > 1) ? $clog2(PERIODO_BASE) : 1;
    localparam int NW = (NIVEIS > 1) ? $clog2(NIVEIS) : 1;
    localparam int SW = (TICKS_SAQUE > 1) ? $clog2(TICKS_SAQUE) : 1;

    localparam logic [CW-1:0] BASE_C    = CW'(PERIODO_BASE);
    localparam logic [CW-1:0] PASSO_C   = CW'(PASSO);
    localparam logic [NW-1:0] NIVEL_MAX = NW'(NIVEIS - 1);
    localparam logic [SW-1:0] SERVE_FIM = SW'(TICKS_SAQUE - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SAQUE   = 2'd1,
        JOGANDO = 2'd2,
        PAUSA   = 2'd3
    } estado_t;

    estado_t       r_estado;
    logic [CW-1:0] r_contagem;
    logic [NW-1:0] r_nivel;
    logic [SW-1:0] r_serve;
    logic          r_retorno;
    logic          r_tick;
    logic          r_saque;
    logic          r_jogando;

    logic [CW-1:0] w_periodo;
    logic [CW-1:0] w_limite;
    logic          w_wrap;
    logic [CW-1:0] w_cont_prox;
    logic          w_reinicia;

    // Period is evaluated at prescaler width so a level change takes effect
    // on the very next comparison without touching the running count.
    assign w_periodo   = BASE_C - (CW'(r_nivel) * PASSO_C);
    assign w_limite    = w_periodo - CW'(1);
    assign w_wrap      = (r_contagem >= w_limite);
    assign w_cont_prox = w_wrap ? '0 : (r_contagem + CW'(1));

    // Start wins everywhere except PAUSA; a point only counts while playing.
    assign w_reinicia = (bus.iniciar && (r_estado != PAUSA))
                      || (bus.ponto && (r_estado == JOGANDO));

    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            r_estado   <= OCIOSO;
            r_contagem <= '0;
            r_nivel    <= '0;
            r_serve    <= '0;
            r_retorno  <= 1'b0;
            r_tick     <= 1'b0;
            r_saque    <= 1'b0;
            r_jogando  <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_saque <= 1'b0;
            if (w_reinicia) begin
                r_estado   <= SAQUE;
                r_jogando  <= 1'b0;
                r_contagem <= '0;
                r_nivel    <= '0;
                r_serve    <= '0;
            end else begin
                case (r_estado)
                    OCIOSO: begin
                        r_contagem <= '0;
                    end
                    SAQUE: begin
                        if (bus.pausar) begin
                            r_estado  <= PAUSA;
                            r_retorno <= 1'b0;
                        end else begin
                            r_contagem <= w_cont_prox;
                            if (w_wrap) begin
                                if (r_serve == SERVE_FIM) begin
                                    r_estado  <= JOGANDO;
                                    r_jogando <= 1'b1;
                                    r_saque   <= 1'b1;
                                    r_serve   <= '0;
                                end else begin
                                    r_serve <= r_serve + SW'(1);
                                end
                            end
                        end
                    end
                    JOGANDO: begin
                        if (bus.pausar) begin
                            r_estado  <= PAUSA;
                            r_retorno <= 1'b1;
                            r_jogando <= 1'b0;
                        end else begin
                            r_contagem <= w_cont_prox;
                            r_tick     <= w_wrap;
                            if (bus.rebatida && (r_nivel != NIVEL_MAX)) begin
                                r_nivel <= r_nivel + NW'(1);
                            end
                        end
                    end
                    PAUSA: begin
                        // r_retorno: 1 = resume into JOGANDO, 0 = resume into SAQUE.
                        if (bus.pausar) begin
                            r_estado  <= r_retorno ? JOGANDO : SAQUE;
                            r_jogando <= r_retorno;
                        end
                    end
                    default: begin
                        r_estado <= OCIOSO;
                    end
                endcase
            end
        end
    end

    assign bus.tick    = r_tick;
    assign bus.saque   = r_saque;
    assign bus.jogando = r_jogando;
    assign bus.nivel   = r_nivel;
    assign bus.estado  = r_estado;
endmodule

// File: tb/tb_escalonador_jogo.sv
// Directed bench for escalonador_jogo with PERIODO_BASE=10, PASSO=2, NIVEIS=4, TICKS_SAQUE=3.
// Strobe events are predicted into a queue and checked by an independent monitor.
module tb_escalonador_jogo;
    localparam int W = 22;

    logic clock;
    logic zera_n;
    int   cyc;
    int   n_vec;
    int   n_fail;

    logic [W-1:0] exp_q[$];

    escalonador_jogo_if #(.NIVEIS(4)) bus ();

    escalonador_jogo #(
        .PERIODO_BASE(10),
        .PASSO       (2),
        .NIVEIS      (4),
        .TICKS_SAQUE (3)
    ) dut (
        .clock (clock),
        .zera_n(zera_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc++;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached at edge %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input int c, input logic [1:0] kind,
                                        input logic [1:0] niv, input logic [1:0] est);
        return {16'(c), kind, niv, est};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Called at a negedge; the pulse is sampled at the next rising edge,
    // whose number is returned.
    task automatic pulse(input logic ini, input logic pau, input logic reb,
                         input logic pon, output int e);
        bus.iniciar  = ini;
        bus.pausar   = pau;
        bus.rebatida = reb;
        bus.ponto    = pon;
        @(negedge clock);
        bus.iniciar  = 1'b0;
        bus.pausar   = 1'b0;
        bus.rebatida = 1'b0;
        bus.ponto    = 1'b0;
        e = cyc;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        if (zera_n && (bus.tick === 1'b1 || bus.saque === 1'b1)) begin
            act = {16'(cyc), bus.saque, bus.tick, bus.nivel, bus.estado};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL evento_inesperado: got saque=%0b tick=%0b at edge %0d, expected no event",
                         bus.saque, bus.tick, cyc);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL evento: got edge=%0d kind=%0d nivel=%0d estado=%0d, expected edge=%0d kind=%0d nivel=%0d estado=%0d",
                             act[21:6], act[5:4], act[3:2], act[1:0],
                             e[21:6], e[5:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0, t, p1, s, p2, s2, r, p3, s3, e4, dummy;
        n_vec        = 0;
        n_fail       = 0;
        zera_n       = 1'b0;
        bus.iniciar  = 1'b0;
        bus.pausar   = 1'b0;
        bus.rebatida = 1'b0;
        bus.ponto    = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_tick",    int'(bus.tick),    0);
        check("reset_saque",   int'(bus.saque),   0);
        check("reset_jogando", int'(bus.jogando), 0);
        check("reset_nivel",   int'(bus.nivel),   0);
        check("reset_estado",  int'(bus.estado),  0);
        zera_n = 1'b1;
        repeat (2) @(negedge clock);
        check("ocioso_espera", int'(bus.estado), 0);

        // Start and serve: saque at E0+30, ticks at E0+40/50/60
        pulse(1, 0, 0, 0, e0);
        check("inicio_estado", int'(bus.estado), 1);
        check("inicio_tick",   int'(bus.tick),   0);
        exp_q.push_back(ev(e0 + 30, 2'b10, 2'd0, 2'd2));
        exp_q.push_back(ev(e0 + 40, 2'b01, 2'd0, 2'd2));
        exp_q.push_back(ev(e0 + 50, 2'b01, 2'd0, 2'd2));
        exp_q.push_back(ev(e0 + 60, 2'b01, 2'd0, 2'd2));
        wait_until(e0 + 29);
        check("saque_antes_estado", int'(bus.estado), 1);
        wait_until(e0 + 30);
        check("saque_estado",  int'(bus.estado),  2);
        check("saque_jogando", int'(bus.jogando), 1);
        wait_until(e0 + 60);

        // Speed levels: rebatida right after each tick -> spacing 8, 6, 4, 4
        t = e0 + 60;
        exp_q.push_back(ev(t + 8,  2'b01, 2'd1, 2'd2));
        exp_q.push_back(ev(t + 14, 2'b01, 2'd2, 2'd2));
        exp_q.push_back(ev(t + 18, 2'b01, 2'd3, 2'd2));
        exp_q.push_back(ev(t + 22, 2'b01, 2'd3, 2'd2));
        pulse(0, 0, 1, 0, dummy);
        check("nivel_1", int'(bus.nivel), 1);
        wait_until(t + 8);
        pulse(0, 0, 1, 0, dummy);
        check("nivel_2", int'(bus.nivel), 2);
        wait_until(t + 14);
        pulse(0, 0, 1, 0, dummy);
        check("nivel_3", int'(bus.nivel), 3);
        wait_until(t + 18);
        pulse(0, 0, 1, 0, dummy);
        check("nivel_satura", int'(bus.nivel), 3);
        wait_until(t + 22);

        // Point at max level -> back to serve
        pulse(0, 0, 0, 1, p1);
        check("ponto_estado", int'(bus.estado), 1);
        check("ponto_nivel",  int'(bus.nivel),  0);
        exp_q.push_back(ev(p1 + 30, 2'b10, 2'd0, 2'd2));
        s = p1 + 30;

        // rebatida coinciding with a wrap: tick plus level step, twice
        exp_q.push_back(ev(s + 10, 2'b01, 2'd1, 2'd2));
        exp_q.push_back(ev(s + 18, 2'b01, 2'd2, 2'd2));
        wait_until(s + 9);
        pulse(0, 0, 1, 0, dummy);
        check("rebatida_wrap_nivel", int'(bus.nivel), 1);
        wait_until(s + 17);
        pulse(0, 0, 1, 0, dummy);
        check("rebatida_wrap_nivel2", int'(bus.nivel), 2);

        // Point at nivel 2
        wait_until(s + 19);
        pulse(0, 0, 0, 1, p2);
        check("ponto2_estado", int'(bus.estado), 1);
        check("ponto2_nivel",  int'(bus.nivel),  0);
        check("ponto2_tick",   int'(bus.tick),   0);
        exp_q.push_back(ev(p2 + 30, 2'b10, 2'd0, 2'd2));
        s2 = p2 + 30;

        // Pause at contagem=5, hold 20 cycles, resume -> tick 5 edges later
        wait_until(s2 + 5);
        pulse(0, 1, 0, 0, dummy);
        check("pausa_estado",  int'(bus.estado),  3);
        check("pausa_jogando", int'(bus.jogando), 0);
        wait_until(s2 + 25);
        check("pausa_mantida", int'(bus.estado), 3);
        pulse(0, 1, 0, 0, r);
        check("retoma_estado",  int'(bus.estado),  2);
        check("retoma_jogando", int'(bus.jogando), 1);
        exp_q.push_back(ev(r + 5, 2'b01, 2'd0, 2'd2));

        // ponto + rebatida + wrap together -> serve, nivel 0, no tick
        wait_until(r + 14);
        pulse(0, 0, 1, 1, p3);
        check("simult_estado", int'(bus.estado), 1);
        check("simult_nivel",  int'(bus.nivel),  0);
        check("simult_tick",   int'(bus.tick),   0);
        exp_q.push_back(ev(p3 + 30, 2'b10, 2'd0, 2'd2));
        s3 = p3 + 30;

        // Reset between edges while tick is high and nivel is 1
        exp_q.push_back(ev(s3 + 10, 2'b01, 2'd1, 2'd2));
        wait_until(s3 + 9);
        pulse(0, 0, 1, 0, dummy);
        #1;
        zera_n = 1'b0;
        #1;
        check("zera_tick",    int'(bus.tick),    0);
        check("zera_saque",   int'(bus.saque),   0);
        check("zera_jogando", int'(bus.jogando), 0);
        check("zera_nivel",   int'(bus.nivel),   0);
        check("zera_estado",  int'(bus.estado),  0);
        repeat (3) @(negedge clock);
        zera_n = 1'b1;
        repeat (15) @(negedge clock);
        check("pos_zera_ocioso", int'(bus.estado), 0);
        pulse(1, 0, 0, 0, e4);
        check("reinicio_estado", int'(bus.estado), 1);
        exp_q.push_back(ev(e4 + 30, 2'b10, 2'd0, 2'd2));
        wait_until(e4 + 32);

        check("fila_pendente", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
